tiger_ins_burst_adapter: RTL and testbench
==========================================

Name: tiger_ins_burst_adapter

Overview:
- Sits between the instruction cache's burst read master and the system instruction bus, which is pipelined and single-word only.
- Accepts one burst read command at a time from the cache.
- Breaks each burst into consecutive single-word pipelined reads with lock held, then returns the data words to the cache in order with a one-cycle register stage.

Parameters:
ADDR_W, 32, address width, byte addressed on both sides
DATA_W, 32, data width on both sides; the word stride is DATA_W/8 bytes
BURST_W, 6, width of the burstcount field
MAX_PENDING, 4, maximum outstanding master reads; power of two, at least 1

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
avs_read  in  1  burst read request from the cache
avs_beginbursttransfer  in  1  first-cycle burst marker, qualifies avs_read
avs_address  in  ADDR_W  burst start byte address, word aligned
avs_burstcount  in  BURST_W  number of words in the burst
avs_waitrequest  out  1  command not accepted
avs_readdata  out  DATA_W  returned word
avs_readdatavalid  out  1  avs_readdata valid
avm_read  out  1  single-word read command
avm_address  out  ADDR_W  read byte address
avm_lock  out  1  held for the whole burst
avm_waitrequest  in  1  command stalled by the fabric
avm_readdata  in  DATA_W  read data
avm_readdatavalid  in  1  avm_readdata valid

Behaviour:
- Interface (decided): one clock, clk; reset is asynchronous and active-low on reset_n.
- Reset values, applied asynchronously: state IDLE, avs_waitrequest=1, avm_read=0, avm_lock=0, avs_readdatavalid=0, avs_readdata=0, all counters 0.
- States:
  - IDLE: avs_waitrequest=0. A cycle with avs_read and avs_beginbursttransfer both high and avs_burstcount != 0 accepts the command.
    - On accept, latch addr=avs_address, issue_left=burstcount, ret_left=burstcount, then go to ISSUE.
    - avs_read without beginbursttransfer is ignored.
    - burstcount==0 is ignored; the block stays in IDLE.
  - ISSUE: avs_waitrequest=1, avm_lock=1.
    - avm_read=1 whenever issue_left!=0 and pending<MAX_PENDING; avm_address=addr.
    - A command is issued in any cycle where avm_read=1 and avm_waitrequest=0. On issue: addr += DATA_W/8, wrapping modulo 2^ADDR_W; issue_left--.
    - avm_read and avm_address stay stable while avm_waitrequest=1.
    - When issue_left reaches 0, go to DRAIN.
  - DRAIN: avs_waitrequest=1, avm_lock=1, avm_read=0. Wait until ret_left==0, then go to IDLE. avm_lock drops in the cycle IDLE is entered.
- pending counter, width clog2(MAX_PENDING)+1:
  - +1 on issue, -1 on avm_readdatavalid.
  - Issue and return in the same cycle leave it unchanged.
  - It never exceeds MAX_PENDING and never underflows.
- Return path:
  - Each avm_readdatavalid registers avm_readdata into avs_readdata and pulses avs_readdatavalid high the next cycle (latency 1).
  - ret_left decrements on each avm_readdatavalid.
  - Data order equals issue order; no reordering.
- Last return:
  - If the final return arrives while still in ISSUE, which is possible only if the last issue and last return share a cycle, the block goes directly to IDLE.
  - A new burst is not accepted until the cycle after entering IDLE.
- avm_readdatavalid while in IDLE, or with ret_left==0, is dropped. It produces no avs_readdatavalid and no counter underflow.
- Reset asserted mid-burst aborts the burst immediately: all outputs take their reset values. Any bus returns that arrive after reset deasserts are dropped per the previous rule.
- A burst always finishes before the next one is accepted; there is no overlap between bursts.

Test Plan:
- Basic burst: burst addr=0x1000, count=8, avm_waitrequest=0, bus returns data=addr one cycle after each issue -> 8 avm_reads at 0x1000..0x101C, avs_readdatavalid pulses carry 0x1000..0x101C in order, avm_lock high from the cycle after accept until IDLE, avs_waitrequest=0 in IDLE only.
- Back-pressure: avm_waitrequest high for 3 cycles on the 2nd command, count=4 -> avm_address holds 0x1004 stable during the stall, exactly 4 issues, 4 returns.
- Pending cap: MAX_PENDING=4, return latency 10 cycles, count=8 -> at most 4 reads outstanding, issue pauses after the 4th read and resumes on the first return, 8 words returned.
- Wrap and degenerate: addr=0xFFFFFFF8, count=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4. Separately, burstcount=0 -> no avm_read, stays IDLE.
- Stray data: avm_readdatavalid pulsed while IDLE -> no avs_readdatavalid, next burst of count=2 completes normally with 2 returns.
- Async reset: reset_n low mid-ISSUE after 3 of 8 issues -> avm_read=0, avm_lock=0, avs_waitrequest=1 in the same cycle. After release, late returns are ignored and a new burst of count=2 completes correctly.

Source files
------------

// File: rtl/tiger_ins_burst_adapter.sv
// Burst-to-single-word read adapter: splits one cache burst read into locked,
// pipelined single-word bus reads and returns the data in order one cycle later.

module tiger_ins_burst_adapter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int BURST_W     = 6,
   parameter int MAX_PENDING = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              avs_read,
   input  logic              avs_beginbursttransfer,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic [BURST_W-1:0] avs_burstcount,
   output logic              avs_waitrequest,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_readdatavalid,
   output logic              avm_read,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_lock,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid
);

   localparam int PEND_W = $clog2(MAX_PENDING) + 1;
   localparam logic [PEND_W-1:0]  MAX_PEND = PEND_W'(MAX_PENDING);
   localparam logic [PEND_W-1:0]  ONE_P    = PEND_W'(1);
   localparam logic [PEND_W-1:0]  ZERO_P   = {PEND_W{1'b0}};
   localparam logic [BURST_W-1:0] ONE_B    = BURST_W'(1);
   localparam logic [BURST_W-1:0] ZERO_B   = {BURST_W{1'b0}};
   localparam logic [ADDR_W-1:0]  STRIDE   = ADDR_W'(DATA_W / 8);
   localparam logic [ADDR_W-1:0]  ZERO_A   = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0]  ZERO_D   = {DATA_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BURST_W-1:0]  issue_left_q, issue_left_d;
   logic [BURST_W-1:0]  ret_left_q, ret_left_d;
   logic [PEND_W-1:0]   pending_q, pending_d;
   logic                avs_waitrequest_q, avs_waitrequest_d;
   logic [DATA_W-1:0]   avs_readdata_q, avs_readdata_d;
   logic                avs_readdatavalid_q, avs_readdatavalid_d;
   logic                avm_read_q, avm_read_d;
   logic                avm_lock_q, avm_lock_d;
   logic                issue_s;
   logic                ret_s;
   logic                accept_s;

   assign issue_s  = avm_read_q & ~avm_waitrequest;
   // Returns outside a burst, or beyond the words still owed, are dropped.
   assign ret_s    = avm_readdatavalid & (state_q != ST_IDLE) & (ret_left_q != ZERO_B);
   assign accept_s = (state_q == ST_IDLE) & ~avs_waitrequest_q & avs_read
                     & avs_beginbursttransfer & (avs_burstcount != ZERO_B);

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d             = state_q;
      addr_d              = addr_q;
      issue_left_d        = issue_left_q;
      ret_left_d          = ret_left_q;
      avs_readdata_d      = avs_readdata_q;
      avs_readdatavalid_d = 1'b0;

      if (issue_s) begin
         addr_d       = addr_q + STRIDE;
         issue_left_d = issue_left_q - ONE_B;
      end else begin
         addr_d       = addr_q;
         issue_left_d = issue_left_q;
      end

      if (ret_s) begin
         ret_left_d          = ret_left_q - ONE_B;
         avs_readdata_d      = avm_readdata;
         avs_readdatavalid_d = 1'b1;
      end else begin
         ret_left_d          = ret_left_q;
         avs_readdata_d      = avs_readdata_q;
         avs_readdatavalid_d = 1'b0;
      end

      if (issue_s && !ret_s) begin
         pending_d = pending_q + ONE_P;
      end else if (!issue_s && ret_s && (pending_q != ZERO_P)) begin
         pending_d = pending_q - ONE_P;
      end else begin
         pending_d = pending_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               addr_d       = avs_address;
               issue_left_d = avs_burstcount;
               ret_left_d   = avs_burstcount;
               state_d      = ST_ISSUE;
            end else begin
               state_d      = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // Last issue and last return in the same cycle skip DRAIN entirely.
            if (ret_left_d == ZERO_B) begin
               state_d = ST_IDLE;
            end else if (issue_left_d == ZERO_B) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (ret_left_d == ZERO_B) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      avs_waitrequest_d = (state_d != ST_IDLE);
      avm_lock_d        = (state_d != ST_IDLE);
      avm_read_d        = (state_d == ST_ISSUE) && (issue_left_d != ZERO_B)
                          && (pending_d < MAX_PEND);
   end

   // State, counters and outputs; reset aborts any burst in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q             <= ST_IDLE;
         addr_q              <= ZERO_A;
         issue_left_q        <= ZERO_B;
         ret_left_q          <= ZERO_B;
         pending_q           <= ZERO_P;
         avs_waitrequest_q   <= 1'b1;
         avs_readdata_q      <= ZERO_D;
         avs_readdatavalid_q <= 1'b0;
         avm_read_q          <= 1'b0;
         avm_lock_q          <= 1'b0;
      end else begin
         state_q             <= state_d;
         addr_q              <= addr_d;
         issue_left_q        <= issue_left_d;
         ret_left_q          <= ret_left_d;
         pending_q           <= pending_d;
         avs_waitrequest_q   <= avs_waitrequest_d;
         avs_readdata_q      <= avs_readdata_d;
         avs_readdatavalid_q <= avs_readdatavalid_d;
         avm_read_q          <= avm_read_d;
         avm_lock_q          <= avm_lock_d;
      end
   end

   assign avs_waitrequest   = avs_waitrequest_q;
   assign avs_readdata      = avs_readdata_q;
   assign avs_readdatavalid = avs_readdatavalid_q;
   assign avm_read          = avm_read_q;
   assign avm_address       = addr_q;
   assign avm_lock          = avm_lock_q;

endmodule

// File: tb/tb_tiger_ins_burst_adapter.sv
// Bench for tiger_ins_burst_adapter: directed bursts against a bus slave model
// and a queue-based reference of expected addresses and returned words.

module tb_tiger_ins_burst_adapter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 6;
   localparam int MP = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          avs_read;
   logic          avs_beginbursttransfer;
   logic [AW-1:0] avs_address;
   logic [BW-1:0] avs_burstcount;
   logic          avs_waitrequest;
   logic [DW-1:0] avs_readdata;
   logic          avs_readdatavalid;
   logic          avm_read;
   logic [AW-1:0] avm_address;
   logic          avm_lock;
   logic          avm_waitrequest;
   logic [DW-1:0] avm_readdata;
   logic          avm_readdatavalid;

   tiger_ins_burst_adapter #(
      .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .MAX_PENDING(MP)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .avs_read(avs_read), .avs_beginbursttransfer(avs_beginbursttransfer),
      .avs_address(avs_address), .avs_burstcount(avs_burstcount),
      .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
      .avs_readdatavalid(avs_readdatavalid),
      .avm_read(avm_read), .avm_address(avm_address), .avm_lock(avm_lock),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] data;
      int          gen;
   } ret_t;

   // Knobs written by the stimulus, read by the compare process.
   int   lat       = 1;
   int   stall_at  = -1;
   int   stall_len = 0;
   logic stray_en  = 1'b0;
   string       lit_name [64];
   logic [31:0] lit_act  [64];
   logic [31:0] lit_exp  [64];
   int          lit_wr = 0;

   // Owned by the compare process.
   int          n_checks   = 0;
   int          n_fail     = 0;
   int          n_issue    = 0;
   int          n_ret      = 0;
   int          max_out    = 0;
   int          stall_hits = 0;
   logic [31:0] last_addr  = 32'h0;
   logic [31:0] exp_issue [$];
   logic [31:0] exp_ret   [$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Hand-computed expectations posted by the stimulus, evaluated by the compare process.
   task automatic post(string name, logic [31:0] act, logic [31:0] exp);
      lit_name[lit_wr % 64] = name;
      lit_act[lit_wr % 64]  = act;
      lit_exp[lit_wr % 64]  = exp;
      lit_wr++;
   endtask

   initial begin : compare
      int          cyc = 0;
      int          gen = 0;
      int          outstanding = 0;
      int          lit_rd = 0;
      int          stall_cnt = 0;
      logic        first_after = 1'b1;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_addr = 32'h0;
      logic        exp_wait;
      ret_t        pipe [$];
      ret_t        r;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'h0;
      forever begin
         @(negedge clk);
         cyc++;
         while (lit_rd != lit_wr) begin
            check(lit_name[lit_rd % 64], lit_act[lit_rd % 64], lit_exp[lit_rd % 64]);
            lit_rd++;
         end
         if (!reset_n) begin
            exp_issue.delete();
            exp_ret.delete();
            outstanding = 0;
            gen++;
            first_after = 1'b1;
            prev_stall  = 1'b0;
            avm_waitrequest = 1'b0;
            check("rst_waitrequest", 32'(avs_waitrequest), 32'h1);
            check("rst_avm_read", 32'(avm_read), 32'h0);
            check("rst_avm_lock", 32'(avm_lock), 32'h0);
            check("rst_readdatavalid", 32'(avs_readdatavalid), 32'h0);
         end
         // Bus slave: returns the issued address as data after lat cycles.
         avm_readdatavalid = 1'b0;
         avm_readdata      = 32'h0;
         if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            r = pipe.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = r.data;
            if (r.gen == gen && outstanding > 0) outstanding--;
         end else if (stray_en) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'hBAD0_0BAD;
         end
         if (reset_n) begin
            if (avs_readdatavalid) begin
               n_ret++;
               if (exp_ret.size() == 0) check("unexpected_readdatavalid", 32'h1, 32'h0);
               else check("readdata", avs_readdata, exp_ret.pop_front());
            end
            exp_wait    = first_after || (exp_ret.size() != 0);
            first_after = 1'b0;
            check("waitrequest", 32'(avs_waitrequest), 32'(exp_wait));
            check("lock", 32'(avm_lock), 32'(exp_ret.size() != 0));
            if (prev_stall) begin
               check("stall_read_held", 32'(avm_read), 32'h1);
               check("stall_addr_held", avm_address, prev_addr);
            end
            if (!exp_wait && avs_read && avs_beginbursttransfer && avs_burstcount != 6'd0) begin
               for (int i = 0; i < int'(avs_burstcount); i++) begin
                  exp_issue.push_back(avs_address + 32'(i * 4));
                  exp_ret.push_back(avs_address + 32'(i * 4));
               end
            end
            avm_waitrequest = 1'b0;
            if (avm_read && n_issue == stall_at && stall_cnt < stall_len) begin
               avm_waitrequest = 1'b1;
               stall_cnt++;
               if (avm_address == 32'h0000_1004) stall_hits++;
            end
            if (avm_read && !avm_waitrequest) begin
               if (exp_issue.size() == 0) check("unexpected_issue", 32'h1, 32'h0);
               else check("issue_addr", avm_address, exp_issue.pop_front());
               r.due  = cyc + lat;
               r.data = avm_address;
               r.gen  = gen;
               pipe.push_back(r);
               outstanding++;
               n_issue++;
               last_addr = avm_address;
               if (outstanding > max_out) max_out = outstanding;
            end
            check("outstanding_cap", 32'(outstanding <= MP), 32'h1);
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
         end
      end
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic burst(logic [31:0] addr, logic [5:0] cnt);
      avs_read               = 1'b1;
      avs_beginbursttransfer = 1'b1;
      avs_address            = addr;
      avs_burstcount         = cnt;
      step(1);
      avs_read               = 1'b0;
      avs_beginbursttransfer = 1'b0;
   endtask

   task automatic wait_idle(int budget);
      int k = 0;
      while ((exp_ret.size() != 0 || exp_issue.size() != 0) && k < budget) begin
         step(1);
         k++;
      end
      if (k >= budget) post("burst_timeout", 32'h0, 32'h1);
      step(2);
   endtask

   initial begin : stimulus
      int bi;
      int br;
      reset_n                = 1'b1;
      avs_read               = 1'b0;
      avs_beginbursttransfer = 1'b0;
      avs_address            = 32'h0;
      avs_burstcount         = 6'd0;
      #1 reset_n = 1'b0;
      #1;
      post("reset_waitrequest", 32'(avs_waitrequest), 32'h1);
      post("reset_avm_read", 32'(avm_read), 32'h0);
      post("reset_avm_lock", 32'(avm_lock), 32'h0);
      post("reset_readdatavalid", 32'(avs_readdatavalid), 32'h0);
      post("reset_readdata", avs_readdata, 32'h0);
      step(3);
      reset_n = 1'b1;
      step(2);

      // Basic burst of 8 words from 0x1000.
      lat = 1; bi = n_issue; br = n_ret;
      burst(32'h0000_1000, 6'd8);
      wait_idle(100);
      post("basic_issues", 32'(n_issue - bi), 32'd8);
      post("basic_returns", 32'(n_ret - br), 32'd8);
      post("basic_last_addr", last_addr, 32'h0000_101C);
      post("basic_idle_wait", 32'(avs_waitrequest), 32'h0);

      // Back-pressure: 3 stall cycles on the second command.
      bi = n_issue; br = n_ret;
      stall_at = n_issue + 1; stall_len = 3;
      burst(32'h0000_1000, 6'd4);
      wait_idle(100);
      post("bp_stall_at_1004", 32'(stall_hits), 32'd3);
      post("bp_issues", 32'(n_issue - bi), 32'd4);
      post("bp_returns", 32'(n_ret - br), 32'd4);

      // Pending cap with 10-cycle return latency.
      lat = 10; bi = n_issue; br = n_ret;
      burst(32'h0000_3000, 6'd8);
      wait_idle(300);
      post("cap_max_outstanding", 32'(max_out), 32'd4);
      post("cap_returns", 32'(n_ret - br), 32'd8);

      // Address wrap at the top of the address space.
      lat = 1; bi = n_issue;
      burst(32'hFFFF_FFF8, 6'd4);
      wait_idle(100);
      post("wrap_issues", 32'(n_issue - bi), 32'd4);
      post("wrap_last_addr", last_addr, 32'h0000_0004);

      // burstcount 0, and read without the burst marker, are both ignored.
      bi = n_issue;
      burst(32'h0000_5000, 6'd0);
      avs_read = 1'b1; avs_burstcount = 6'd4;
      step(2);
      avs_read = 1'b0;
      step(4);
      post("ignored_no_issue", 32'(n_issue - bi), 32'd0);
      post("ignored_stays_idle", 32'(avs_waitrequest), 32'h0);
      post("ignored_no_lock", 32'(avm_lock), 32'h0);

      // Stray bus data while idle, then a normal 2-word burst.
      br = n_ret;
      stray_en = 1'b1;
      step(1);
      stray_en = 1'b0;
      step(3);
      post("stray_dropped", 32'(n_ret - br), 32'd0);
      burst(32'h0000_6000, 6'd2);
      wait_idle(100);
      post("stray_next_returns", 32'(n_ret - br), 32'd2);

      // Asynchronous reset after 3 of 8 issues.
      lat = 10; bi = n_issue;
      burst(32'h0000_7000, 6'd8);
      for (int k = 0; k < 100 && (n_issue - bi) < 3; k++) step(1);
      post("abort_issue_count", 32'(n_issue - bi), 32'd3);
      reset_n = 1'b0;
      #1;
      post("abort_avm_read", 32'(avm_read), 32'h0);
      post("abort_avm_lock", 32'(avm_lock), 32'h0);
      post("abort_waitrequest", 32'(avs_waitrequest), 32'h1);
      step(2);
      reset_n = 1'b1;
      br = n_ret;
      step(15);
      post("abort_late_dropped", 32'(n_ret - br), 32'd0);
      lat = 1;
      burst(32'h0000_8000, 6'd2);
      wait_idle(100);
      post("abort_next_returns", 32'(n_ret - br), 32'd2);
      post("abort_next_last_addr", last_addr, 32'h0000_8004);

      step(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
